// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encodings and constants for the I2C write master
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_LOAD     = 3'd4,
    ST_DATA     = 3'd5,
    ST_DATA_ACK = 3'd6,
    ST_STOP     = 3'd7
  } i2c_state_e;

  // R/W bit appended to the 7-bit address; this master only writes
  localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_qtick_gen.sv
// rtl/i2c_qtick_gen.sv - SCL quarter-period divider and quarter index counter
module i2c_qtick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic       qtick,
  output logic [1:0] q
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  // qtick marks the last clk of a quarter; it cannot fire while frozen
  assign qtick = en && (div == DW'(CLK_DIV - 1));

  // divider counts clk within a quarter, q counts quarters within a bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      q   <= 2'd0;
    end else if (clr) begin
      div <= '0;
      q   <= 2'd0;
    end else if (qtick) begin
      div <= '0;
      q   <= q + 2'd1;
    end else if (en) begin
      div <= div + DW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_wr.sv
// rtl/i2c_master_wr.sv - I2C write-only master with streamed payload bytes
module i2c_master_wr import i2c_pkg::*; #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       slave_addr,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  input  logic             tx_last,
  output logic             tx_ready,
  input  logic             sda_i,
  output logic             scl_oe,
  output logic             sda_oe,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  output logic [CNT_W-1:0] bytes_sent
);

  i2c_state_e state, state_nxt;

  logic       qtick;
  logic [1:0] q;
  logic       bit_end;
  logic       ack_samp;
  logic       start_ok;
  logic       div_en;
  logic       div_clr;
  logic [7:0] shreg;
  logic [2:0] bitcnt;
  logic       last_flag;
  logic       ack_bit;
  logic       scl_nxt;
  logic       sda_nxt;

  assign bit_end  = qtick && (q == 2'd3);
  assign ack_samp = qtick && (q == 2'd2);
  // a start coinciding with done is dropped so the bus sees a clean idle cycle
  assign start_ok = start && !done;
  assign busy     = (state != ST_IDLE);
  assign tx_ready = (state == ST_LOAD) && tx_valid;

  // LOAD without data freezes the divider, stretching the SCL low phase;
  // the handshake cycle itself counts as the first clk of the next bit
  assign div_clr = (state == ST_IDLE);
  assign div_en  = !((state == ST_LOAD) && !tx_valid);

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .clr   (div_clr),
    .qtick (qtick),
    .q     (q)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state decode; bit-level transitions happen at the end of quarter 3
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start_ok) state_nxt = ST_START;
      ST_START:    if (bit_end) state_nxt = ST_ADDR;
      ST_ADDR:     if (bit_end && bitcnt == 3'd7) state_nxt = ST_ADDR_ACK;
      ST_ADDR_ACK: if (bit_end) state_nxt = ack_bit ? ST_STOP : ST_LOAD;
      ST_LOAD:     if (tx_valid) state_nxt = ST_DATA;
      ST_DATA:     if (bit_end && bitcnt == 3'd7) state_nxt = ST_DATA_ACK;
      ST_DATA_ACK: if (bit_end) state_nxt = (ack_bit || last_flag) ? ST_STOP : ST_LOAD;
      ST_STOP:     if (bit_end) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // shifter, bit counter, ACK capture, status flags and byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= 8'd0;
      bitcnt     <= 3'd0;
      last_flag  <= 1'b0;
      ack_bit    <= 1'b0;
      nack_err   <= 1'b0;
      bytes_sent <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            shreg      <= {slave_addr, I2C_WR};
            bitcnt     <= 3'd0;
            nack_err   <= 1'b0;
            bytes_sent <= '0;
          end
        end
        ST_ADDR, ST_DATA: begin
          if (bit_end) begin
            shreg  <= {shreg[6:0], 1'b0};
            bitcnt <= bitcnt + 3'd1;
          end
        end
        ST_ADDR_ACK: begin
          if (ack_samp) ack_bit <= sda_i;
          if (bit_end && ack_bit) nack_err <= 1'b1;
        end
        ST_LOAD: begin
          if (tx_valid) begin
            shreg     <= tx_data;
            last_flag <= tx_last;
          end
        end
        ST_DATA_ACK: begin
          if (ack_samp) ack_bit <= sda_i;
          if (bit_end) begin
            if (ack_bit) nack_err <= 1'b1;
            else if (bytes_sent != {CNT_W{1'b1}}) bytes_sent <= bytes_sent + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // pad drive for the current state/quarter; within a bit SDA moves only once
  // the registered SCL is already low, so data never changes with SCL released
  always_comb begin
    scl_nxt = 1'b0;
    sda_nxt = sda_oe;
    case (state)
      ST_IDLE: begin
        scl_nxt = 1'b0;
        sda_nxt = 1'b0;
      end
      ST_START: begin
        scl_nxt = 1'b0;
        sda_nxt = q[1];
      end
      ST_ADDR, ST_DATA: begin
        scl_nxt = ~q[1];
        if (q == 2'd0 && scl_oe) sda_nxt = ~shreg[7];
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        scl_nxt = ~q[1];
        if (q == 2'd0 && scl_oe) sda_nxt = 1'b0;
      end
      ST_LOAD: begin
        scl_nxt = 1'b1;
      end
      ST_STOP: begin
        case (q)
          2'd0: begin
            scl_nxt = 1'b1;
            if (scl_oe) sda_nxt = 1'b1;
          end
          2'd1: begin
            scl_nxt = 1'b0;
            sda_nxt = 1'b1;
          end
          default: begin
            scl_nxt = 1'b0;
            sda_nxt = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
  end

  // registered open-drain enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
    end else begin
      scl_oe <= scl_nxt;
      sda_oe <= sda_nxt;
    end
  end

endmodule

// File: doc/i2c_master_wr.md
Name: i2c_master_wr

Overview:
Parametrised I2C write-only master. It generates START, a 7-bit address with W=0, and an unbounded stream of data bytes fed over a valid/ready interface, sampling ACK after every byte, then STOP.
- Open-drain outputs with a programmable SCL rate; the controller holds SCL low while waiting for data.
- Sits between the register/DMA front end and the pad ring.
- Replaces the fixed single-byte FSM controller.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-period; legal range >= 2. Bit period = 4*CLK_DIV clk cycles.
- CNT_W, 8, width of the byte counter output bytes_sent.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a transfer; ignored while busy=1
- slave_addr  in  7  target address; sampled on the accepted start
- tx_data  in  8  byte to send, MSB first
- tx_valid  in  1  tx_data/tx_last valid
- tx_last  in  1  the byte offered is the final byte
- tx_ready  out  1  one-cycle pulse; byte is consumed on tx_valid&tx_ready
- sda_i  in  1  synchronised SDA pad input, used for ACK sampling
- scl_oe  out  1  1 = drive SCL low, 0 = release
- sda_oe  out  1  1 = drive SDA low, 0 = release
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after STOP completes
- nack_err  out  1  sticky; set on NACK; cleared on the next accepted start
- bytes_sent  out  CNT_W  data bytes ACKed in the current/last transfer; saturates at all-ones

Behaviour:
- Reset values: scl_oe=0, sda_oe=0 (bus released), tx_ready=0, busy=0, done=0, nack_err=0, bytes_sent=0, state=IDLE, divider=0.
- Reset asserted mid-transfer: outputs return to the reset values asynchronously. No STOP is generated.
- Divider: a qtick pulse fires every CLK_DIV clk cycles while busy. Quarter index q counts 0..3 and advances on qtick. The divider is held at 0 in IDLE.
- Per-bit waveform: q0,q1 SCL low (sda_oe updated at q0 entry); q2,q3 SCL released. sda_i is sampled on the last clk of q2.
- States: IDLE, START, ADDR, ADDR_ACK, LOAD, DATA, DATA_ACK, STOP.
- IDLE -> START on start. In the same cycle: busy=1, nack_err cleared, bytes_sent=0, shift register <= {slave_addr,1'b0}.
- START, 4 quarters: q0,q1 SCL and SDA released; q2,q3 SDA low with SCL released. Then -> ADDR.
- ADDR: 8 bits MSB first; sda_oe = ~bit.
- ADDR_ACK: sda_oe=0 for one bit period. Sampled sda_i=0 -> LOAD. sda_i=1 -> nack_err=1 and -> STOP.
- LOAD:
  - SCL held low, SDA held at its current level.
  - tx_ready pulses high in the first LOAD cycle with tx_valid=1. On that cycle the shifter <= tx_data, the last_flag <= tx_last, and the state -> DATA.
  - If tx_valid=0, stay in LOAD indefinitely; the SCL low phase is stretched.
- DATA: 8 bits as in ADDR. Then -> DATA_ACK.
- DATA_ACK, ACK (sda_i=0): bytes_sent++. last_flag=1 -> STOP; else -> LOAD.
- DATA_ACK, NACK: nack_err=1 -> STOP; bytes_sent unchanged.
- STOP, 4 quarters: q0 SCL low, SDA low; q1 SCL released, SDA low; q2,q3 both released. Then done=1 for one cycle, busy=0, -> IDLE.
- Timing: the first START quarter begins the cycle after the accepted start. Unstalled, a transfer of N bytes lasts (1+9+9N+1)*4*CLK_DIV clk cycles from the accepted start to the done pulse.
- start while busy: ignored, with no effect on the current transfer.
- start in the same cycle as done: ignored; accepted from the following cycle.
- tx_valid outside LOAD is ignored and tx_ready stays 0.
- scl_oe and sda_oe are registered outputs with no combinational paths from inputs.
- SDA changes only while SCL is low, except during START and STOP.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum constants (3-bit encodings: IDLE=0, START=1, ADDR=2, ADDR_ACK=3, LOAD=4, DATA=5, DATA_ACK=6, STOP=7);
  - the W bit constant I2C_WR=1'b0.
- One sub-module, i2c_qtick_gen: the divider plus the quarter counter. Parameter CLK_DIV; inputs en and clr; outputs qtick and q[1:0].
- The FSM, the shifter and the counters stay in i2c_master_wr.

Test Plan:
- Single byte: CLK_DIV=4, addr=7'h50, one byte 8'hA5 with tx_last=1, slave ACKs all -> bus model decodes START, 0xA0, A5, STOP. done pulses at cycle 1+20*16. bytes_sent=1, nack_err=0.
- Address NACK: addr=7'h3C, slave never ACKs -> STOP immediately after the address ACK bit. nack_err=1, bytes_sent=0, tx_ready never asserted.
- Multi-byte with stall: bytes 11,22,33 (last on 33); tx_valid is withheld 50 cycles before byte 22 -> scl_oe stays 1 for those cycles, with no SDA change while SCL is released. Bus sees 11 22 33; bytes_sent=3.
- Data NACK: the slave NACKs the 2nd of 4 bytes -> STOP follows that ACK bit; bytes_sent=1, nack_err=1. A subsequent start clears nack_err.
- Reset mid-ADDR bit 3: scl_oe=sda_oe=busy=0 within the reset assertion. After release, a fresh start with addr 7'h12 completes normally.
- Start while busy, plus CLK_DIV=2 rerun: a second start pulse during DATA is ignored and a single transfer is seen. Bit period measured as 8 clk.
